instr_decode_stage: RTL and testbench

//  Registered RISC-V instruction decode stage between the fetch buffer and the register-file/ALU stage.

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/instr_field_decode.sv | 51 +++++
 rtl/instr_decode_stage.sv | 167 ++++++++++++++++
 tb/tb_instr_decode_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode values,
// instruction-format encoding and the packed decoded-field bundle.
package decode_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
        fmt_e       fmt;
        logic       illegal;
    } fields_t;

    localparam int FIELDS_W = $bits(fields_t);

    // Opcode to format lookup. The opcode includes instr[1:0], so any
    // compressed-space encoding (low bits != 2'b11) falls into FMT_NONE.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OPC_OP:                                                  f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: f = FMT_I;
            OPC_STORE:                                               f = FMT_S;
            OPC_BRANCH:                                              f = FMT_B;
            OPC_LUI, OPC_AUIPC:                                      f = FMT_U;
            OPC_JAL:                                                 f = FMT_J;
            default:                                                 f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational RV32I field splitter: instruction word to
// register/function fields, format code, illegal flag and sign-extended
// immediate (zero for R-format and illegal encodings).
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output fields_t         fields,
    output logic [XLEN-1:0] imm
);

    fmt_e        fmt_s;
    logic [31:0] imm32_s;

    // Classify the instruction by its opcode.
    always_comb begin
        fmt_s = fmt_of(instr[6:0]);
    end

    // Reassemble the immediate from its per-format bit scatter.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'h000};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'h0000_0000;
        endcase
    end

    // Split the raw fields; they are reported even for illegal encodings.
    always_comb begin
        fields         = '0;
        fields.funct7  = instr[31:25];
        fields.rs2     = instr[24:20];
        fields.rs1     = instr[19:15];
        fields.funct3  = instr[14:12];
        fields.rd      = instr[11:7];
        fields.opcode  = instr[6:0];
        fields.fmt     = fmt_s;
        fields.illegal = (fmt_s == FMT_NONE);
    end

    // Sign-extend the 32-bit immediate to the configured data width.
    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage with a 2-entry skid buffer (main + skid)
// so the input side sustains one instruction per cycle under backpressure.
// Optional feature: define DECODE_STATS_EN to add the stat_decoded and
// stat_illegal delivery counters.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e          state_r;
    logic            out_valid_r;
    logic            in_ready_r;
    fields_t         main_fields_r;
    logic [XLEN-1:0] main_imm_r;
    logic [PC_W-1:0] main_pc_r;
    fields_t         skid_fields_r;
    logic [XLEN-1:0] skid_imm_r;
    logic [PC_W-1:0] skid_pc_r;

    fields_t         dec_fields_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            in_fire_s;
    logic            out_fire_s;

    instr_field_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr  (in_instr),
        .fields (dec_fields_s),
        .imm    (dec_imm_s)
    );

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Occupancy FSM: main register feeds the outputs, skid catches the one
    // extra bundle accepted while the output is stalled. Flush wins over
    // any transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_EMPTY;
            out_valid_r   <= 1'b0;
            in_ready_r    <= 1'b1;
            main_fields_r <= '0;
            main_imm_r    <= '0;
            main_pc_r     <= '0;
            skid_fields_r <= '0;
            skid_imm_r    <= '0;
            skid_pc_r     <= '0;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_fields_r <= dec_fields_s;
                        main_imm_r    <= dec_imm_s;
                        main_pc_r     <= in_pc;
                        out_valid_r   <= 1'b1;
                        state_r       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        skid_fields_r <= dec_fields_s;
                        skid_imm_r    <= dec_imm_s;
                        skid_pc_r     <= in_pc;
                        in_ready_r    <= 1'b0;
                        state_r       <= ST_FULL;
                    end else if (!in_fire_s && out_fire_s) begin
                        out_valid_r   <= 1'b0;
                        state_r       <= ST_EMPTY;
                    end else if (in_fire_s && out_fire_s) begin
                        main_fields_r <= dec_fields_s;
                        main_imm_r    <= dec_imm_s;
                        main_pc_r     <= in_pc;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_fields_r <= skid_fields_r;
                        main_imm_r    <= skid_imm_r;
                        main_pc_r     <= skid_pc_r;
                        in_ready_r    <= 1'b1;
                        state_r       <= ST_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = main_pc_r;
    assign out_opcode  = main_fields_r.opcode;
    assign out_rd      = main_fields_r.rd;
    assign out_funct3  = main_fields_r.funct3;
    assign out_rs1     = main_fields_r.rs1;
    assign out_rs2     = main_fields_r.rs2;
    assign out_funct7  = main_fields_r.funct7;
    assign out_imm     = main_imm_r;
    assign out_fmt     = main_fields_r.fmt;
    assign out_illegal = main_fields_r.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded_r;
    logic [31:0] stat_illegal_r;

    // Delivery counters: count every output handshake, including one that
    // coincides with a flush; they wrap naturally and ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_decoded_r <= 32'd0;
            stat_illegal_r <= 32'd0;
        end else if (out_fire_s) begin
            stat_decoded_r <= stat_decoded_r + 32'd1;
            if (main_fields_r.illegal) begin
                stat_illegal_r <= stat_illegal_r + 32'd1;
            end
        end
    end

    assign stat_decoded = stat_decoded_r;
    assign stat_illegal = stat_illegal_r;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenario tasks plus a
// scoreboard monitor that checks every delivered bundle in FIFO order.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_illegal;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_dec = 0;
    int exp_ill = 0;
    logic [63:0] exp_q[$];

    instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
`ifdef DECODE_STATS_EN
        , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_fmt(input logic [31:0] i);
        case (i[6:0])
            7'h33:                             return 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 3'd1;
            7'h23:                             return 3'd2;
            7'h63:                             return 3'd3;
            7'h37, 7'h17:                      return 3'd4;
            7'h6F:                             return 3'd5;
            default:                           return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        logic signed [31:0] s;
        logic signed [31:0] t;
        logic [31:0] r;
        s = i;
        case (exp_fmt(i))
            3'd1: r = s >>> 20;
            3'd2: begin t = s >>> 25; r = (t << 5) | {27'd0, i[11:7]}; end
            3'd3: begin t = s >>> 31; r = (t << 12) | {20'd0, i[7], i[30:25], i[11:8], 1'b0}; end
            3'd4: r = i & 32'hFFFF_F000;
            3'd5: begin t = s >>> 31; r = (t << 20) | {12'd0, i[19:12], i[20], i[30:21], 1'b0}; end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive the input side; record the bundle if it will be accepted.
    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc, output bit acc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        acc = v && in_ready && !flush && rst_n;
        if (acc) exp_q.push_back({pc, ins});
    endtask

    // Scoreboard: compare each output handshake against the oldest accepted input.
    task automatic monitor();
        logic [63:0] e;
        logic [99:0] got;
        logic [99:0] want;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                got = {out_pc, out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode,
                       out_imm, out_fmt, out_illegal};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got bundle %h, expected no output", got);
                end else begin
                    e = exp_q.pop_front();
                    want = {e[63:32], e[31:25], e[24:20], e[19:15], e[14:12], e[11:7], e[6:0],
                            exp_imm(e[31:0]), exp_fmt(e[31:0]), (exp_fmt(e[31:0]) == 3'd7)};
                    exp_dec++;
                    if (exp_fmt(e[31:0]) == 3'd7) exp_ill++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL sb_bundle: got %h, expected %h", got, want);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({out_valid, in_ready, out_pc, out_imm, out_fmt, out_illegal, out_rd} !== {1'b0, 1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b ready=%b pc=%h imm=%h fmt=%0d ill=%b, expected 0/1/0/0/0/0",
                     out_valid, in_ready, out_pc, out_imm, out_fmt, out_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        bit acc;
        out_ready = 1'b1;
        set_in(1'b1, 32'hFFB1_0093, 32'h100, acc);
        cyc();
        n_vec++;
        if ({out_valid, out_rd, out_rs1, out_fmt, out_imm} !== {1'b1, 5'd1, 5'd2, 3'd1, 32'hFFFF_FFFB}) begin
            n_err++;
            $display("FAIL addi: got v=%b rd=%0d rs1=%0d fmt=%0d imm=%h, expected 1/1/2/1/fffffffb",
                     out_valid, out_rd, out_rs1, out_fmt, out_imm);
        end
        set_in(1'b1, 32'hFE20_8CE3, 32'h104, acc);
        cyc();
        n_vec++;
        if ({out_valid, out_fmt, out_imm} !== {1'b1, 3'd3, 32'hFFFF_FFF8}) begin
            n_err++;
            $display("FAIL beq: got v=%b fmt=%0d imm=%h, expected 1/3/fffffff8", out_valid, out_fmt, out_imm);
        end
        set_in(1'b1, 32'h0053_2623, 32'h108, acc);
        cyc();
        n_vec++;
        if ({out_valid, out_fmt, out_imm, out_rs1, out_rs2} !== {1'b1, 3'd2, 32'd12, 5'd6, 5'd5}) begin
            n_err++;
            $display("FAIL sw: got v=%b fmt=%0d imm=%h rs1=%0d rs2=%0d, expected 1/2/c/6/5",
                     out_valid, out_fmt, out_imm, out_rs1, out_rs2);
        end
        set_in(1'b0, 32'd0, 32'd0, acc);
        cyc();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s [4];
        int idx;
        bit acc;
        s[0] = 32'h0050_0113; s[1] = 32'h1234_5037; s[2] = 32'h0080_00EF; s[3] = 32'hFFFF_F197;
        idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, s[idx], 32'h200 + 32'(idx * 4), acc);
            if (acc) idx++;
            cyc();
            n_vec++;
            if (in_ready !== ((i == 0) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL bp_in_ready cycle %0d: got %b, expected %b", i, in_ready, (i == 0));
            end
        end
        n_vec++;
        if (idx !== 2) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d, expected 2", idx);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_no_bubble cycle %0d: got out_valid=%b, expected 1", i, out_valid);
            end
            if (idx < 4) begin
                set_in(1'b1, s[idx], 32'h200 + 32'(idx * 4), acc);
                if (acc) idx++;
            end else begin
                set_in(1'b0, 32'd0, 32'd0, acc);
            end
            cyc();
        end
        n_vec++;
        if ({out_valid, 32'(exp_q.size())} !== {1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL bp_drained: got out_valid=%b pending=%0d, expected 0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_flush();
        bit acc;
        out_ready = 1'b0;
        set_in(1'b1, 32'h0010_0093, 32'h300, acc);
        cyc();
        set_in(1'b1, 32'h0020_0093, 32'h304, acc);
        cyc();
        flush = 1'b1;
        set_in(1'b1, 32'h0030_0093, 32'h308, acc);
        cyc();
        exp_q.delete();
        flush = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, acc);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped: got out_valid=%b, expected 0", out_valid);
        end
        set_in(1'b1, 32'h0040_0093, 32'h30C, acc);
        cyc();
        flush = 1'b1;
        set_in(1'b1, 32'h0050_0093, 32'h310, acc);
        cyc();
        flush = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, acc);
        n_vec++;
        if ({out_valid, 32'(exp_q.size())} !== {1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL flush_one: got out_valid=%b pending=%0d, expected 0/0", out_valid, exp_q.size());
        end
        exp_q.delete();
        cyc();
    endtask

    task automatic test_illegal();
        bit acc;
        int ill0;
        out_ready = 1'b1;
`ifdef DECODE_STATS_EN
        ill0 = int'(stat_illegal);
`else
        ill0 = 0;
`endif
        set_in(1'b1, 32'h0000_0000, 32'h400, acc);
        cyc();
        n_vec++;
        if ({out_valid, out_illegal, out_fmt, out_imm} !== {1'b1, 1'b1, 3'd7, 32'd0}) begin
            n_err++;
            $display("FAIL illegal_zero: got v=%b ill=%b fmt=%0d imm=%h, expected 1/1/7/0",
                     out_valid, out_illegal, out_fmt, out_imm);
        end
        set_in(1'b1, 32'h0000_007F, 32'h404, acc);
        cyc();
        n_vec++;
        if ({out_valid, out_illegal, out_fmt, out_imm} !== {1'b1, 1'b1, 3'd7, 32'd0}) begin
            n_err++;
            $display("FAIL illegal_7f: got v=%b ill=%b fmt=%0d imm=%h, expected 1/1/7/0",
                     out_valid, out_illegal, out_fmt, out_imm);
        end
        set_in(1'b0, 32'd0, 32'd0, acc);
        cyc();
`ifdef DECODE_STATS_EN
        n_vec++;
        if (int'(stat_illegal) - ill0 !== 2) begin
            n_err++;
            $display("FAIL stat_illegal_delta: got %0d, expected 2", int'(stat_illegal) - ill0);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [31:0] r;
        logic [31:0] pc;
        bit acc;
        int budget;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h2B};
        pc = 32'h1000;
        for (int i = 0; i < 80; i++) begin
            r = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            set_in(1'($urandom_range(0, 1)), {r[31:7], ops[$urandom_range(0, 11)]}, pc, acc);
            if (acc) pc = pc + 32'd4;
            cyc();
        end
        set_in(1'b0, 32'd0, 32'd0, acc);
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cyc();
            budget++;
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d pending after %0d cycles, expected 0", exp_q.size(), budget);
        end
`ifdef DECODE_STATS_EN
        n_vec++;
        if ({stat_decoded, stat_illegal} !== {32'(exp_dec), 32'(exp_ill)}) begin
            n_err++;
            $display("FAIL stats: got dec=%0d ill=%0d, expected %0d/%0d", stat_decoded, stat_illegal, exp_dec, exp_ill);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit acc;
        out_ready = 1'b0;
        set_in(1'b1, 32'h0060_0093, 32'h500, acc);
        cyc();
        set_in(1'b1, 32'h0070_0093, 32'h504, acc);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, acc);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_mid_full: got out_valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_dec = 0;
        exp_ill = 0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, out_pc, out_imm} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL rst_mid_async: got v=%b rdy=%b pc=%h imm=%h, expected 0/1/0/0", out_valid, in_ready, out_pc, out_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_after: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        set_in(1'b1, 32'h0080_0093, 32'h508, acc);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, acc);
        n_vec++;
        if ({out_valid, out_pc} !== {1'b1, 32'h508}) begin
            n_err++;
            $display("FAIL rst_mid_resume: got v=%b pc=%h, expected 1/508", out_valid, out_pc);
        end
        cyc();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
